// File: rtl/pdm_source_gen_pkg.sv
// Shared state type, synchroniser depth and dither LFSR constants for the PDM source generator.
package pdm_source_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    localparam int          SYNC_STAGES = 2;
    localparam logic [15:0] LFSR_POLY   = 16'hB400;
    localparam logic [15:0] LFSR_SEED   = 16'hACE1;

    // Galois form of x^16 + x^14 + x^13 + x^11 + 1.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/pdm_source_gen_fifo.sv
// Synchronous frame FIFO with occupancy output; clear_i wins over push and pop.
module pdm_source_gen_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           clear_i,
    input  logic                           push_i,
    input  logic [WIDTH-1:0]               wdata_i,
    input  logic                           pop_i,
    output logic [WIDTH-1:0]               rdata_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(DEPTH+1)-1:0]     level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             do_push, do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o & ~clear_i;
    assign do_pop  = pop_i & ~empty_o & ~clear_i;

    // NOTE: storage has no reset; the pointers and level define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/pdm_source_gen.sv
// PCM-to-PDM first-order modulator fed from a frame FIFO, stepped by a synchronised PDM clock.
// Optional feature: define PDM_SOURCE_GEN_DITHER_EN to add LFSR carry-in dither.
module pdm_source_gen
    import pdm_source_gen_pkg::*;
#(
    parameter int NUM_CH     = 1,
    parameter int PCM_WIDTH  = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int OSR        = 64
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                en_i,
    input  logic                                clear_i,
    input  logic                                pdm_clk_i,
    input  logic [NUM_CH*PCM_WIDTH-1:0]         pcm_data_i,
    input  logic                                pcm_valid_i,
    output logic                                pcm_ready_o,
    output logic                                pdm_data_o,
    output logic                                underrun_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level_o
);
    localparam int FRAME_W = NUM_CH * PCM_WIDTH;
    localparam int CNT_W   = $clog2(OSR);
    localparam int CH1     = NUM_CH - 1;
    localparam logic [PCM_WIDTH-1:0] MSB_MASK = {1'b1, {(PCM_WIDTH-1){1'b0}}};

    state_e                 state_q, state_d;
    logic [FRAME_W-1:0]     frame_q, frame_d;
    logic [PCM_WIDTH-1:0]   acc_q [NUM_CH];
    logic [PCM_WIDTH-1:0]   acc_d [NUM_CH];
    logic [PCM_WIDTH:0]     sum   [NUM_CH];
    logic [CNT_W-1:0]       osr_cnt_q, osr_cnt_d;
    logic                   pdm_q, pdm_d;
    logic                   underrun_q, underrun_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lvl_q, rise_q, fall_q;
    logic                   cin;

    logic                   fifo_full, fifo_empty, fifo_avail, push, pop;
    logic [FRAME_W-1:0]     fifo_rdata;

    assign pcm_ready_o = ~fifo_full;
    assign push        = pcm_valid_i & pcm_ready_o;
    assign fifo_avail  = ~fifo_empty & ~clear_i;

    pdm_source_gen_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (push),
        .wdata_i (pcm_data_i),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level_o)
    );

    // Edge pulses are registered so a step lands 3 cycles after the first sampling edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            lvl_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pdm_clk_i};
            lvl_q  <= sync_q[SYNC_STAGES-1];
            rise_q <= sync_q[SYNC_STAGES-1] & ~lvl_q;
            fall_q <= ~sync_q[SYNC_STAGES-1] & lvl_q;
        end
    end

`ifdef PDM_SOURCE_GEN_DITHER_EN
    logic [15:0] lfsr_q;
    logic        step_en;

    assign step_en = en_i & (state_q == ST_RUN) & (rise_q | (fall_q & (NUM_CH == 2)));
    assign cin     = lfsr_q[0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      lfsr_q <= LFSR_SEED;
        else if (step_en) lfsr_q <= lfsr_next(lfsr_q);
    end
`else
    assign cin = 1'b0;
`endif

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            sum[c] = {1'b0, acc_q[c]}
                   + {1'b0, frame_q[c*PCM_WIDTH +: PCM_WIDTH] ^ MSB_MASK}
                   + {{PCM_WIDTH{1'b0}}, cin};
        end
    end

    always_comb begin
        // NOTE: every output of this block is given a default first, so no latch is inferred.
        state_d    = state_q;
        frame_d    = frame_q;
        acc_d      = acc_q;
        osr_cnt_d  = osr_cnt_q;
        pdm_d      = pdm_q;
        underrun_d = underrun_q;
        pop        = 1'b0;

        if (!en_i) begin
            state_d   = ST_IDLE;
            pdm_d     = 1'b0;
            acc_d     = '{default: '0};
            osr_cnt_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    pdm_d     = 1'b0;
                    acc_d     = '{default: '0};
                    osr_cnt_d = '0;
                    state_d   = ST_PRIME;
                end
                ST_PRIME: begin
                    if (fifo_avail) begin
                        pop     = 1'b1;
                        frame_d = fifo_rdata;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (rise_q) begin
                        acc_d[0] = sum[0][PCM_WIDTH-1:0];
                        pdm_d    = sum[0][PCM_WIDTH];
                        if (osr_cnt_q == CNT_W'(OSR - 1)) begin
                            osr_cnt_d = '0;
                            // An empty FIFO leaves the current frame in place.
                            if (fifo_avail) begin
                                pop     = 1'b1;
                                frame_d = fifo_rdata;
                            end else if (!clear_i) begin
                                underrun_d = 1'b1;
                            end
                        end else begin
                            osr_cnt_d = osr_cnt_q + CNT_W'(1);
                        end
                    end else if (fall_q && (NUM_CH == 2)) begin
                        acc_d[CH1] = sum[CH1][PCM_WIDTH-1:0];
                        pdm_d      = sum[CH1][PCM_WIDTH];
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (clear_i) underrun_d = 1'b0;
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            frame_q    <= '0;
            acc_q      <= '{default: '0};
            osr_cnt_q  <= '0;
            pdm_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            acc_q      <= acc_d;
            osr_cnt_q  <= osr_cnt_d;
            pdm_q      <= pdm_d;
            underrun_q <= underrun_d;
        end
    end

    assign pdm_data_o = pdm_q;
    assign underrun_o = underrun_q;

endmodule

// File: tb/tb_pdm_source_gen.sv
// Directed bench for pdm_source_gen: a mono and a stereo instance, OSR=8, FIFO depth 4.
module tb_pdm_source_gen;

    logic        clk = 1'b0;
    logic        rst_n, clear, pdm_clk;
    logic        en_a, valid_a, ready_a, pdm_a, und_a;
    logic [15:0] data_a;
    logic [2:0]  lvl_a;
    logic        en_b, valid_b, ready_b, pdm_b, und_b;
    logic [31:0] data_b;
    logic [2:0]  lvl_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pdm_source_gen #(.NUM_CH(1), .PCM_WIDTH(16), .FIFO_DEPTH(4), .OSR(8)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en_a), .clear_i(clear), .pdm_clk_i(pdm_clk),
        .pcm_data_i(data_a), .pcm_valid_i(valid_a), .pcm_ready_o(ready_a),
        .pdm_data_o(pdm_a), .underrun_o(und_a), .fifo_level_o(lvl_a)
    );

    pdm_source_gen #(.NUM_CH(2), .PCM_WIDTH(16), .FIFO_DEPTH(4), .OSR(8)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en_b), .clear_i(clear), .pdm_clk_i(pdm_clk),
        .pcm_data_i(data_b), .pcm_valid_i(valid_b), .pcm_ready_o(ready_b),
        .pdm_data_o(pdm_b), .underrun_o(und_b), .fifo_level_o(lvl_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Change the PDM clock level and wait until the 3-cycle output latency has elapsed.
    task automatic pdm_edge(input logic lvl);
        pdm_clk = lvl;
        repeat (4) @(negedge clk);
    endtask

    task automatic push_a(input logic [15:0] d);
        data_a  = d;
        valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; clear = 1'b0; pdm_clk = 1'b0;
        en_a = 1'b0; valid_a = 1'b0; data_a = '0;
        en_b = 1'b0; valid_b = 1'b0; data_b = '0;
        repeat (3) @(negedge clk);
        check("rst_pdm", pdm_a, 0);
        check("rst_und", und_a, 0);
        check("rst_lvl", lvl_a, 0);
        check("rst_ready", ready_a, 1);
        check("rst_pdm_b", pdm_b, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Frame 0x0000: alternating bits, then underrun with the frame held.
        push_a(16'h0000);
        check("push_lvl", lvl_a, 1);
        en_a = 1'b1;
        repeat (4) @(negedge clk);
        check("prime_pop_lvl", lvl_a, 0);
        check("prime_pdm", pdm_a, 0);
        pdm_edge(1'b1);
        check("z_rise1", pdm_a, 0);
        pdm_edge(1'b0);
        pdm_clk = 1'b1;
        repeat (3) @(negedge clk);
        check("latency_early", pdm_a, 0);
        @(negedge clk);
        check("latency_exact", pdm_a, 1);
        pdm_edge(1'b0);
        check("mono_fall_hold", pdm_a, 1);
        for (int i = 3; i <= 7; i++) begin
            pdm_edge(1'b1);
            check($sformatf("z_rise%0d", i), pdm_a, (i % 2 == 0) ? 1 : 0);
            pdm_edge(1'b0);
        end
        check("no_und_before_wrap", und_a, 0);
        pdm_edge(1'b1);
        check("z_rise8", pdm_a, 1);
        check("und_set", und_a, 1);
        pdm_edge(1'b0);
        pdm_edge(1'b1);
        check("held_rise9", pdm_a, 0);
        pdm_edge(1'b0);
        pdm_edge(1'b1);
        check("held_rise10", pdm_a, 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("und_cleared", und_a, 0);
        pdm_edge(1'b0);

        // Frames 0x8000 then 0x7FFF, with a push landing on the wrap pop.
        en_a = 1'b0;
        @(negedge clk);
        check("idle_pdm", pdm_a, 0);
        push_a(16'h8000);
        push_a(16'h7FFF);
        check("idle_accepts_push", lvl_a, 2);
        en_a = 1'b1;
        repeat (4) @(negedge clk);
        check("run_lvl", lvl_a, 1);
        for (int i = 1; i <= 7; i++) begin
            pdm_edge(1'b1);
            check($sformatf("min_rise%0d", i), pdm_a, 0);
            pdm_edge(1'b0);
        end
        pdm_clk = 1'b1;
        repeat (3) @(negedge clk);
        data_a  = 16'h7FFF;
        valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        check("min_rise8", pdm_a, 0);
        check("push_pop_lvl", lvl_a, 1);
        pdm_edge(1'b0);
        pdm_edge(1'b1);
        check("max_first", pdm_a, 0);
        pdm_edge(1'b0);
        for (int i = 10; i <= 17; i++) begin
            pdm_edge(1'b1);
            check($sformatf("max_rise%0d", i), pdm_a, 1);
            pdm_edge(1'b0);
        end
        check("max_lvl", lvl_a, 0);
        check("max_no_und", und_a, 0);

        // Fill a depth-4 FIFO while disabled.
        en_a = 1'b0;
        valid_a = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            data_a = 16'(k);
            @(negedge clk);
            check($sformatf("fill_lvl%0d", k), lvl_a, (k < 4) ? k : 4);
            check($sformatf("fill_ready%0d", k), ready_a, (k < 4) ? 1 : 0);
        end
        valid_a = 1'b0;

        // Reset in the middle of RUN with 3 frames queued.
        en_a = 1'b1;
        repeat (4) @(negedge clk);
        check("rr_lvl", lvl_a, 3);
        pdm_edge(1'b1);
        pdm_edge(1'b0);
        pdm_edge(1'b1);
        check("rr_pdm_before", pdm_a, 1);
        pdm_edge(1'b0);
        rst_n = 1'b0;
        #1;
        check("rr_pdm", pdm_a, 0);
        check("rr_und", und_a, 0);
        check("rr_lvl0", lvl_a, 0);
        check("rr_ready", ready_a, 1);
        @(negedge clk);
        rst_n = 1'b1;
        en_a = 1'b0;
        @(negedge clk);

        // clear_i beats a same-cycle push.
        push_a(16'h1234);
        check("clr_pre_lvl", lvl_a, 1);
        data_a = 16'h5678;
        valid_a = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        clear = 1'b0;
        check("clr_prio_lvl", lvl_a, 0);

        // Stereo: ch0 = 0x7FFF on rising edges, ch1 = 0x8000 on falling edges.
        data_b  = 32'h8000_7FFF;
        valid_b = 1'b1;
        @(negedge clk);
        valid_b = 1'b0;
        en_b = 1'b1;
        repeat (4) @(negedge clk);
        check("b_lvl", lvl_b, 0);
        for (int i = 1; i <= 4; i++) begin
            pdm_edge(1'b1);
            check($sformatf("b_rise%0d", i), pdm_b, (i == 1) ? 0 : 1);
            pdm_edge(1'b0);
            check($sformatf("b_fall%0d", i), pdm_b, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pdm_source_gen.md
PDM_SOURCE_GEN -- requirements
Module: pdm_source_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 1, number of channels; legal values 1 and 2.
REQ-002 SHALL have parameter PCM_WIDTH, default 16, signed two's-complement sample width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, frame FIFO depth; power of 2, at least 2.
REQ-004 SHALL have parameter OSR, default 64, PDM bits per PCM frame; at least 2.
REQ-005 SHALL have port clk_i, input, 1 bit, system clock.
REQ-006 SHALL have port rst_ni, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port en_i, input, 1 bit, modulator enable.
REQ-008 SHALL have port clear_i, input, 1 bit, single-cycle flush of FIFO and underrun flag.
REQ-009 SHALL have port pdm_clk_i, input, 1 bit, PDM clock; asynchronous to clk_i.
REQ-010 SHALL have port pcm_data_i, input, NUM_CH*PCM_WIDTH bits, one frame; ch0 in the LSBs.
REQ-011 SHALL have port pcm_valid_i, input, 1 bit, frame valid.
REQ-012 SHALL have port pcm_ready_o, output, 1 bit, frame ready.
REQ-013 SHALL have port pdm_data_o, output, 1 bit, PDM bitstream.
REQ-014 SHALL have port underrun_o, output, 1 bit, sticky underrun flag.
REQ-015 SHALL have port fifo_level_o, output, $clog2(FIFO_DEPTH+1) bits, FIFO occupancy.

Function
REQ-016 SHALL sample pdm_clk_i through a 2-flop synchroniser followed by an edge-detect register.
REQ-017 SHALL update pdm_data_o exactly 3 clk_i cycles after the first clk_i edge that samples a new pdm_clk_i level.
REQ-018 SHALL step ch0 on each synchronised rising edge; with NUM_CH=2 it SHALL step ch1 on each falling edge; with NUM_CH=1 falling edges SHALL be ignored and the output held.
REQ-019 SHALL implement each channel as a first-order modulator: u = sample with MSB inverted; {carry, acc} = acc + u + cin; pdm bit = carry.
REQ-020 SHALL give each channel a PCM_WIDTH-bit accumulator that wraps silently.
REQ-021 SHALL have states IDLE, PRIME and RUN.
REQ-022 In IDLE, pdm_data_o SHALL be 0, accumulators and OSR counter SHALL be 0, and the FIFO SHALL still accept pushes.
REQ-023 SHALL go from IDLE to PRIME when en_i=1.
REQ-024 In PRIME, output SHALL be 0 and no underrun SHALL be flagged.
REQ-025 SHALL go from PRIME to RUN in the cycle the FIFO is non-empty, popping the first frame in that cycle.
REQ-026 In RUN, an OSR counter SHALL count rising edges 0..OSR-1; on wrap the next frame SHALL be popped.
REQ-027 If the FIFO is empty at a pop point, the current frame SHALL be held and underrun_o SHALL be set the next cycle; the block SHALL stay in RUN.
REQ-028 If en_i=0 in any state, the block SHALL enter IDLE the next cycle; FIFO contents SHALL be retained.
REQ-029 pcm_ready_o SHALL equal !full, combinationally; push = pcm_valid_i & pcm_ready_o.
REQ-030 A push while full SHALL be blocked even if a pop occurs in the same cycle.
REQ-031 A simultaneous push and pop on a non-full FIFO SHALL leave fifo_level_o unchanged.
REQ-032 clear_i SHALL empty the FIFO and clear underrun_o the next cycle and SHALL take priority over a same-cycle push or pop.
REQ-033 underrun_o SHALL clear only on clear_i or reset.

Reset
REQ-034 On rst_ni low: state IDLE; pdm_data_o, underrun_o and fifo_level_o 0; accumulators, OSR counter and synchroniser 0; pcm_ready_o 1 (FIFO empty).
REQ-035 Reset asserted mid-operation SHALL discard FIFO contents immediately.

Configuration
REQ-036 With PDM_SOURCE_GEN_DITHER_EN defined, a 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 0xACE1, reset to seed) SHALL advance on every modulator step and supply its bit 0 as cin.
REQ-037 Without PDM_SOURCE_GEN_DITHER_EN, cin SHALL be 0 and no LFSR SHALL be present; the output SHALL be fully deterministic.

Structure
REQ-038 Package pdm_source_gen_pkg SHALL hold the state enum, LFSR polynomial and seed, and the synchroniser depth constant.
REQ-039 The FIFO SHALL be sub-module pdm_source_gen_fifo: synchronous, with parameters width and depth, and a level output.

Verification (dither off unless stated)
REQ-040 NUM_CH=1, OSR=8, frame 0x0000, en_i=1, pdm_clk toggling -> pdm_data_o 0,1,0,1,... on successive rising edges.
REQ-041 Frame 0x8000 -> all 0; frame 0x7FFF -> first bit 0, then all 1 for the next 8 bits.
REQ-042 One frame pushed, OSR=8 -> after the 8th rising edge underrun_o=1 and the bitstream continues with the held sample; clear_i -> underrun_o=0.
REQ-043 NUM_CH=2, frame {ch1=0x8000, ch0=0x7FFF} -> bits after falling edges 0; bits after rising edges 1 (after the first).
REQ-044 FIFO_DEPTH=4, en_i=0, pcm_valid_i held for 5 frames -> pcm_ready_o drops after the 4th push and fifo_level_o=4.
REQ-045 rst_ni pulsed low mid-RUN with 3 frames queued -> every output at its reset value, fifo_level_o=0; with dither on, the LFSR is back at 0xACE1.
